// File: rtl/frame_filter_sequencer.sv
// Multi-pass ping-pong scheduler for the 1-bit pixel-averaging filter.
// Streams one frame-buffer bank through the filter in raster order and
// writes the filter output into the other bank, alternating for
// num_passes_in passes.
// Ports:
//   clk_in, rst_n_in             clock, async active-low reset
//   start_in, abort_in           job control
//   num_passes_in                passes per job (latched at start)
//   busy_out, done_out           job status
//   result_bank_out              bank holding the final image
//   rd_en/addr/bank_out          frame-buffer read request
//   rd_data_in                   read pixel, RD_LAT cycles after rd_en_out
//   filt_*_out                   filter input stream
//   filt_*_in                    filter output stream
//   wr_en/addr/bank/data_out     frame-buffer write request
module frame_filter_sequencer #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int H_BLANK      = 4,
    parameter int PAD_LINES    = 2,
    parameter int RD_LAT       = 2,
    parameter int DRAIN_CYCLES = 8,
    parameter int ADDR_W       = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [3:0]        num_passes_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              result_bank_out,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_bank_out,
    input  logic              rd_data_in,
    output logic              filt_valid_out,
    output logic              filt_pixel_out,
    output logic [10:0]       filt_hcount_out,
    output logic [9:0]        filt_vcount_out,
    input  logic              filt_valid_in,
    input  logic              filt_pixel_in,
    input  logic [10:0]       filt_hcount_in,
    input  logic [9:0]        filt_vcount_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              wr_bank_out,
    output logic              wr_data_out
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_BLANK - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + PAD_LINES - 1);

    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    // One stream slot: frame marks real frame lines, so the
    // pixel is taken from the read port and pad lines stay 0.
    typedef struct packed {
        logic        valid;
        logic        frame;
        logic [10:0] h;
        logic [9:0]  v;
    } tap_t;

    state_t          state_q, state_d;
    logic [10:0]     h_q, h_d;
    logic [9:0]      v_q, v_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [3:0]      pass_q, pass_d;
    logic [3:0]      npass_q, npass_d;
    logic            bank_q, bank_d;
    logic            result_q;

    tap_t            tap_in;
    tap_t            tap_out;
    tap_t            tap_q [RD_LAT];

    logic            abort_act;
    logic            wr_hit;

    assign abort_act = abort_in && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        drain_d = drain_q;
        pass_d  = pass_q;
        npass_d = npass_q;
        bank_d  = bank_q;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    npass_d = num_passes_in;
                    bank_d  = 1'b0;
                    pass_d  = '0;
                    h_d     = '0;
                    v_d     = '0;
                    drain_d = '0;
                    if (num_passes_in == 4'd0)
                        state_d = DONE;
                    else
                        state_d = STREAM;
                end
            end
            STREAM: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d     = '0;
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        v_d = v_q + 10'd1;
                    end
                end else begin
                    h_d = h_q + 11'd1;
                end
            end
            DRAIN: begin
                if (drain_q == D_LAST)
                    state_d = NEXT;
                else
                    drain_d = drain_q + DW'(1);
            end
            NEXT: begin
                bank_d  = ~bank_q;
                pass_d  = pass_q + 4'd1;
                h_d     = '0;
                v_d     = '0;
                drain_d = '0;
                if (pass_q + 4'd1 == npass_q)
                    state_d = DONE;
                else
                    state_d = STREAM;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins everywhere, including over a start in IDLE.
        if (abort_in)
            state_d = IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            h_q      <= '0;
            v_q      <= '0;
            drain_q  <= '0;
            pass_q   <= '0;
            npass_q  <= '0;
            bank_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            drain_q <= drain_d;
            pass_q  <= pass_d;
            npass_q <= npass_d;
            bank_q  <= bank_d;
            if (done_out)
                result_q <= bank_q;
        end
    end

    always_comb begin
        tap_in = '0;
        if (state_q == STREAM) begin
            tap_in.valid = h_q < H_ACT;
            tap_in.frame = v_q < V_ACT;
            tap_in.h     = h_q;
            tap_in.v     = v_q;
        end
    end

    assign rd_en_out   = tap_in.valid && tap_in.frame;
    assign rd_bank_out = rd_en_out && bank_q;
    assign rd_addr_out = rd_en_out
                       ? ADDR_W'(v_q) * ADDR_W'(H_ACTIVE)
                         + ADDR_W'(h_q)
                       : '0;

    // Delay line matching the frame-buffer read latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < RD_LAT; i++)
                tap_q[i] <= '0;
        end else if (abort_act) begin
            for (int i = 0; i < RD_LAT; i++)
                tap_q[i] <= '0;
        end else begin
            tap_q[0] <= tap_in;
            for (int i = 1; i < RD_LAT; i++)
                tap_q[i] <= tap_q[i-1];
        end
    end

    assign tap_out         = tap_q[RD_LAT-1];
    assign filt_valid_out  = tap_out.valid;
    assign filt_pixel_out  = tap_out.valid && tap_out.frame
                             && rd_data_in;
    assign filt_hcount_out = tap_out.h;
    assign filt_vcount_out = tap_out.v;

    // Pad-line results fall outside the frame and are dropped.
    assign wr_hit = filt_valid_in
                 && (filt_hcount_in < H_ACT)
                 && (filt_vcount_in < V_ACT)
                 && !abort_act;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_bank_out <= 1'b0;
            wr_data_out <= 1'b0;
        end else begin
            wr_en_out <= wr_hit;
            if (wr_hit) begin
                wr_addr_out <= ADDR_W'(filt_vcount_in)
                             * ADDR_W'(H_ACTIVE)
                             + ADDR_W'(filt_hcount_in);
                wr_bank_out <= ~bank_q;
                wr_data_out <= filt_pixel_in;
            end
        end
    end

    assign busy_out        = state_q != IDLE;
    assign done_out        = (state_q == DONE) && !abort_in;
    assign result_bank_out = done_out ? bank_q : result_q;

endmodule
